// File: rtl/vga_pkg.sv
// Shared VGA timing definitions.
// Holds the 640x480@60 default timing, the derived totals, the raster phase
// enum used by both axis timers, and a helper that sums an axis's segments.
package vga_pkg;

  // Width of both raster counters.
  localparam int unsigned CntW = 10;

  localparam int unsigned HActiveDef = 640;
  localparam int unsigned HFpDef     = 16;
  localparam int unsigned HSyncDef   = 96;
  localparam int unsigned HBpDef     = 48;
  localparam int unsigned VActiveDef = 480;
  localparam int unsigned VFpDef     = 10;
  localparam int unsigned VSyncDef   = 2;
  localparam int unsigned VBpDef     = 33;

  function automatic int unsigned axis_total(int unsigned act, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  localparam int unsigned HTotalDef = axis_total(HActiveDef, HFpDef, HSyncDef, HBpDef);
  localparam int unsigned VTotalDef = axis_total(VActiveDef, VFpDef, VSyncDef, VBpDef);

  typedef enum logic [1:0] {
    Active,
    Front,
    Sync,
    Back
  } phase_e;

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: a wrapping counter plus its ACTIVE/FRONT/SYNC/BACK phase.
// Ports:
//   clk, reset (async, active-low), step (advance by one position)
//   count - count that will be held after this clk edge (next-state value)
//   phase - phase that will be held after this clk edge (next-state value)
//   wrap  - this step takes the count from TOTAL-1 back to 0
// Next-state values are exported so the top can register decoded outputs that
// line up with the coordinates in the same cycle.
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = HActiveDef,
  parameter int unsigned FP     = HFpDef,
  parameter int unsigned SYNC   = HSyncDef,
  parameter int unsigned BP     = HBpDef
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step,
  output logic [CntW-1:0] count,
  output phase_e          phase,
  output logic            wrap
);

  localparam int unsigned Total = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CntW-1:0] LastCnt    = CntW'(Total - 1);
  localparam logic [CntW-1:0] FrontStart = CntW'(ACTIVE);
  localparam logic [CntW-1:0] SyncStart  = CntW'(ACTIVE + FP);
  localparam logic [CntW-1:0] BackStart  = CntW'(ACTIVE + FP + SYNC);

  logic [CntW-1:0] count_q, count_d;
  phase_e          phase_q, phase_d;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    wrap    = step && (count_q == LastCnt);
    if (step) begin
      count_d = wrap ? '0 : count_q + CntW'(1);
      case (phase_q)
        Active: if (count_d == FrontStart) phase_d = Front;
        Front:  if (count_d == SyncStart)  phase_d = Sync;
        Sync:   if (count_d == BackStart)  phase_d = Back;
        Back:   if (wrap)                  phase_d = Active;
        default:                           phase_d = Active;
      endcase
    end
  end

  // Reset parks the axis on its last position so the first step lands on 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= LastCnt;
      phase_q <= Back;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count = count_d;
  assign phase = phase_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster/sync generator driven by a one-clk pixel enable.
// Ports:
//   clk, reset (async, active-low), en (pixel enable pulse)
//   hsync, vsync      - sync outputs, asserted level = SYNC_POL
//   video_on          - (px_x, px_y) inside the visible area
//   px_x, px_y        - raster coordinates
//   line_start        - one-clk pulse when px_x becomes 0
//   frame_start       - one-clk pulse when (px_x, px_y) becomes (0,0)
// All outputs are registered from the axis timers' next-state values.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned H_FP     = HFpDef,
  parameter int unsigned H_SYNC   = HSyncDef,
  parameter int unsigned H_BP     = HBpDef,
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter int unsigned V_FP     = VFpDef,
  parameter int unsigned V_SYNC   = VSyncDef,
  parameter int unsigned V_BP     = VBpDef,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic            hsync,
  output logic            vsync,
  output logic            video_on,
  output logic [CntW-1:0] px_x,
  output logic [CntW-1:0] px_y,
  output logic            line_start,
  output logic            frame_start
);

  localparam int unsigned HTotal = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [CntW-1:0] h_count, v_count;
  phase_e          h_phase, v_phase;
  logic            h_wrap, v_wrap;

  vga_axis_timer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_timer (
    .clk   (clk),
    .reset (reset),
    .step  (en),
    .count (h_count),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_axis_timer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_timer (
    .clk   (clk),
    .reset (reset),
    .step  (en && h_wrap),
    .count (v_count),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  logic            hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
  logic            hsync_d, vsync_d, video_on_d;
  logic [CntW-1:0] px_x_q, px_y_q;

  always_comb begin
    hsync_d    = (h_phase == Sync) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = (v_phase == Sync) ? SYNC_POL : ~SYNC_POL;
    video_on_d = (h_phase == Active) && (v_phase == Active);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      px_x_q        <= CntW'(HTotal - 1);
      px_y_q        <= CntW'(VTotal - 1);
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      px_x_q        <= h_count;
      px_y_q        <= v_count;
      // Wraps are qualified by en, so both pulses last exactly one clk.
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
